// File: rtl/fetch_defs.sv
// Definitions shared by the fetch stage and the decoder: PC mux select codes,
// fetch FSM state encoding and the NOP word.
package fetch_defs;

    localparam logic [3:0] PCSEL_SEQ = 4'b0000;
    localparam logic [3:0] PCSEL_BR  = 4'b0001;
    localparam logic [3:0] PCSEL_J   = 4'b0010;
    localparam logic [3:0] PCSEL_JR  = 4'b0011;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Redirect decode and target selection. Without a redirect next_pc_o is the
// sequential successor of pc_i.
module next_pc_sel
    import fetch_defs::*;
(
    input  logic [31:0] pc_i,
    input  logic [3:0]  if_pc_hi_i,
    input  logic [25:0] if_jidx_i,
    input  logic [3:0]  pc_mux_sel_i,
    input  logic        br_taken_i,
    input  logic        redir_en_i,
    input  logic [31:0] br_target_i,
    input  logic [31:0] jr_target_i,
    output logic        redirect_o,
    output logic [31:0] next_pc_o
);

    always_comb begin
        redirect_o = 1'b0;
        next_pc_o  = pc_inc(pc_i);
        if (redir_en_i) begin
            case (pc_mux_sel_i)
                PCSEL_SEQ: next_pc_o = pc_inc(pc_i);
                PCSEL_BR: begin
                    if (br_taken_i) begin
                        redirect_o = 1'b1;
                        next_pc_o  = br_target_i & WORD_MASK;
                    end
                end
                PCSEL_J: begin
                    redirect_o = 1'b1;
                    next_pc_o  = {if_pc_hi_i, if_jidx_i, 2'b00};
                end
                PCSEL_JR: begin
                    // Register value may be misaligned; the PC never is.
                    redirect_o = 1'b1;
                    next_pc_o  = jr_target_i & WORD_MASK;
                end
                default: next_pc_o = pc_inc(pc_i);
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps exactly one imem read in flight
// and fills the IF/ID register consumed by the decoder.
module instr_fetch_stage
    import fetch_defs::fetch_state_e, fetch_defs::S_FETCH, fetch_defs::S_WAIT,
           fetch_defs::S_HOLD, fetch_defs::pc_inc;
#(
    parameter logic [31:0] RESET_PC = fetch_defs::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = fetch_defs::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redir_en,
    input  logic [3:0]  PC_MUX_SEL,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  if_inst_q, if_inst_d;
    logic [31:0]  if_pc_plus4_q, if_pc_plus4_d;
    logic         if_valid_q, if_valid_d;

    logic         redirect;
    logic [31:0]  next_pc;

    next_pc_sel u_next_pc_sel (
        .pc_i         (pc_q),
        .if_pc_hi_i   (if_pc_plus4_q[31:28]),
        .if_jidx_i    (if_inst_q[25:0]),
        .pc_mux_sel_i (PC_MUX_SEL),
        .br_taken_i   (br_taken),
        .redir_en_i   (redir_en),
        .br_target_i  (br_target),
        .jr_target_i  (jr_target),
        .redirect_o   (redirect),
        .next_pc_o    (next_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_d        = kill_q;
        buf_d         = buf_q;
        if_inst_d     = if_inst_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_valid_d    = if_valid_q;

        case (state_q)
            S_FETCH: begin
                state_d = S_WAIT;
                // The request just issued belongs to the wrong path.
                if (redirect) kill_d = 1'b1;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                    kill_d  = 1'b0;
                    if (!kill_q && !redirect) begin
                        if (stall) begin
                            buf_d   = imem_rdata;
                            state_d = S_HOLD;
                        end else begin
                            if_inst_d     = imem_rdata;
                            if_pc_plus4_d = pc_inc(pc_q);
                            if_valid_d    = 1'b1;
                            pc_d          = next_pc;
                        end
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_d = S_FETCH;
                end else if (!stall) begin
                    if_inst_d     = buf_q;
                    if_pc_plus4_d = pc_inc(pc_q);
                    if_valid_d    = 1'b1;
                    pc_d          = next_pc;
                    state_d       = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // A redirect wins over stall and over any word arriving this cycle.
        if (redirect) begin
            pc_d       = next_pc;
            if_inst_d  = NOP_INST;
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            buf_q         <= NOP_INST;
            if_inst_q     <= NOP_INST;
            if_pc_plus4_q <= '0;
            if_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            buf_q         <= buf_d;
            if_inst_q     <= if_inst_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_valid_q    <= if_valid_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH) && !rst;
    assign imem_addr   = pc_q;
    assign if_inst     = if_inst_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_valid    = if_valid_q;

endmodule
